// File: rtl/core_run_ctrl.sv
// Run/debug sequencer for the single-cycle RISC core: holds it in reset, streams a program
// into instruction memory, then gates its clock enable for run, halt and single-step.
module core_run_ctrl #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned AW         = 6,
    parameter int unsigned RST_HOLD   = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             cmd_halt,
    input  logic             cmd_step,
    input  logic             cmd_reset,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    output logic             core_rst,
    output logic             core_en,
    output logic             imem_we,
    output logic [AW-1:0]    imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [2:0]       state_o,
    output logic [31:0]      halt_pc,
    output logic             load_ovf,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [31:0]       Ebreak   = 32'h00100073;
    localparam int unsigned       HoldW    = $clog2(RST_HOLD) + 1;
    localparam logic [HoldW-1:0]  HoldLast = HoldW'(RST_HOLD - 1);
    localparam logic [AW-1:0]     LastAddr = AW'(IMEM_DEPTH - 1);

    typedef enum logic [2:0] {
        StResetHold = 3'd0,
        StIdle      = 3'd1,
        StLoad      = 3'd2,
        StRun       = 3'd3,
        StStep      = 3'd4,
        StHalted    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic               we_q, we_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        halt_pc_q, halt_pc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ret_q, ret_d;
    logic               pend_q, pend_d;
    logic               core_rst_q, ld_ready_q;

    logic is_ebreak, running, accept;

    assign is_ebreak = (instr_in == Ebreak);
    assign running   = (state_q == StRun) || (state_q == StStep);
    assign accept    = (state_q == StLoad) && ld_ready_q && ld_valid;
    assign core_en   = running && !is_ebreak;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        halt_pc_d = halt_pc_q;
        ovf_d     = ovf_q;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        pend_d    = 1'b0;

        // A cmd_halt/step halt captures the PC the core shows one cycle later.
        if (pend_q) begin
            halt_pc_d = pc_in;
        end

        if (running) begin
            cyc_d = cyc_q + 1'b1;
            if (core_en) begin
                ret_d = ret_q + 1'b1;
            end
        end

        if (accept) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = ld_data;
            if (ptr_q != LastAddr) begin
                ptr_d = ptr_q + 1'b1;
            end
        end

        unique case (state_q)
            StResetHold: begin
                if (hold_q == HoldLast) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StIdle, StHalted: begin
                if (cmd_reset)     state_d = StResetHold;
                else if (cmd_step) state_d = StStep;
                else if (cmd_run)  state_d = StRun;
                else if (cmd_load) state_d = StLoad;
            end
            StLoad: begin
                if (cmd_reset) begin
                    state_d = StResetHold;
                end else if (accept) begin
                    if (ld_last) begin
                        state_d = StIdle;
                    end else if (ptr_q == LastAddr) begin
                        ovf_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StRun: begin
                if (cmd_reset) begin
                    state_d = StResetHold;
                end else if (is_ebreak) begin
                    state_d   = StHalted;
                    halt_pc_d = pc_in;
                end else if (cmd_halt) begin
                    state_d = StHalted;
                    pend_d  = 1'b1;
                end
            end
            StStep: begin
                if (cmd_reset) begin
                    state_d = StResetHold;
                end else begin
                    state_d = StHalted;
                    if (is_ebreak) halt_pc_d = pc_in;
                    else           pend_d    = 1'b1;
                end
            end
            default: state_d = StResetHold;
        endcase

        if (state_d == StResetHold && state_q != StResetHold) begin
            hold_d = '0;
        end
        if (state_d == StLoad && state_q != StLoad) begin
            ptr_d  = '0;
            addr_d = '0;
            ovf_d  = 1'b0;
            cyc_d  = '0;
            ret_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StResetHold;
            hold_q     <= '0;
            ptr_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            halt_pc_q  <= '0;
            ovf_q      <= 1'b0;
            cyc_q      <= '0;
            ret_q      <= '0;
            pend_q     <= 1'b0;
            core_rst_q <= 1'b1;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            halt_pc_q  <= halt_pc_d;
            ovf_q      <= ovf_d;
            cyc_q      <= cyc_d;
            ret_q      <= ret_d;
            pend_q     <= pend_d;
            core_rst_q <= (state_d == StResetHold) || (state_d == StIdle) || (state_d == StLoad);
            ld_ready_q <= (state_d == StLoad);
        end
    end

    assign state_o     = state_q;
    assign core_rst    = core_rst_q;
    assign ld_ready    = ld_ready_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign halt_pc     = halt_pc_q;
    assign load_ovf    = ovf_q;
    assign cycle_cnt   = cyc_q;
    assign retired_cnt = ret_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: a tiny core model (PC + instruction memory) drives
// instr_in/pc_in; a second, 4-word instance covers the load overflow path.
module tb_core_run_ctrl;

    localparam logic [31:0] Ebreak = 32'h00100073;
    localparam logic [31:0] Nop    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_load, cmd_run, cmd_halt, cmd_step, cmd_reset;
    logic        ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_ready, core_rst, core_en, imem_we, load_ovf;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata, halt_pc, cycle_cnt, retired_cnt;
    logic [2:0]  state_o;
    logic [31:0] instr_in, pc_in;

    logic        s_cmd_load, s_ld_valid;
    logic        s_ld_ready, s_core_rst, s_core_en, s_imem_we, s_load_ovf;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata, s_halt_pc, s_cycle_cnt, s_retired_cnt;
    logic [2:0]  s_state;

    always #5 clk = ~clk;

    core_run_ctrl #(.IMEM_DEPTH(64), .AW(6), .RST_HOLD(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
        .cmd_step(cmd_step), .cmd_reset(cmd_reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .instr_in(instr_in), .pc_in(pc_in),
        .core_rst(core_rst), .core_en(core_en),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .state_o(state_o), .halt_pc(halt_pc), .load_ovf(load_ovf),
        .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
    );

    core_run_ctrl #(.IMEM_DEPTH(4), .AW(2), .RST_HOLD(4), .CNT_W(32)) dut_small (
        .clk(clk), .rst(rst),
        .cmd_load(s_cmd_load), .cmd_run(1'b0), .cmd_halt(1'b0),
        .cmd_step(1'b0), .cmd_reset(1'b0),
        .ld_valid(s_ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(s_ld_ready),
        .instr_in(Nop), .pc_in(32'h0),
        .core_rst(s_core_rst), .core_en(s_core_en),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .state_o(s_state), .halt_pc(s_halt_pc), .load_ovf(s_load_ovf),
        .cycle_cnt(s_cycle_cnt), .retired_cnt(s_retired_cnt)
    );

    // Core model: PC held at 0 in reset, advances by 4 when enabled.
    logic [31:0] mem [64];
    logic [31:0] pc = 32'h0;
    assign pc_in    = pc;
    assign instr_in = mem[pc[7:2]];

    int          cyc = 0;
    int          acc_cyc[$];
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] sw_addr[$];
    logic [31:0] sw_data[$];

    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        if (core_rst)     pc <= 32'h0;
        else if (core_en) pc <= pc + 32'd4;
        if (ld_valid && ld_ready) acc_cyc.push_back(cyc);
        if (imem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back({26'h0, imem_addr});
            wr_data.push_back(imem_wdata);
        end
        if (s_imem_we) begin
            sw_addr.push_back({30'h0, s_imem_addr});
            sw_data.push_back(s_imem_wdata);
        end
        cyc = cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd_reset_and_wait();
        cmd_reset = 1'b1;
        tick();
        cmd_reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_step();
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
    endtask

    logic [31:0] prog1 [3];
    int          wbase, abase, en_cycles;

    initial begin
        prog1[0] = 32'h00500093;
        prog1[1] = 32'h00100113;
        prog1[2] = Ebreak;
        rst = 1'b0;
        {cmd_load, cmd_run, cmd_halt, cmd_step, cmd_reset} = '0;
        {s_cmd_load, s_ld_valid, ld_valid, ld_last} = '0;
        ld_data = '0;

        // Reset
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_state", {29'h0, state_o}, 32'd0);
        check("rst_core_rst", {31'h0, core_rst}, 32'd1);
        check("rst_core_en", {31'h0, core_en}, 32'd0);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'd0);
        check("rst_halt_pc", halt_pc, 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("hold_3cyc_state", {29'h0, state_o}, 32'd0);
        tick();
        check("hold_4cyc_state", {29'h0, state_o}, 32'd1);

        // Load three beats with gaps
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        check("load_state", {29'h0, state_o}, 32'd2);
        check("load_ld_ready", {31'h0, ld_ready}, 32'd1);
        wbase = wr_addr.size();
        abase = acc_cyc.size();
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog1[i];
            ld_last  = (i == 2);
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            tick();
        end
        check("load_nwrites", wr_addr.size() - wbase, 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (wr_addr.size() > wbase + i && acc_cyc.size() > abase + i) begin
                check($sformatf("load_addr%0d", i), wr_addr[wbase + i], i);
                check($sformatf("load_data%0d", i), wr_data[wbase + i], prog1[i]);
                check($sformatf("load_lat%0d", i), wr_cyc[wbase + i] - acc_cyc[abase + i], 32'd1);
            end
        end
        check("load_done_state", {29'h0, state_o}, 32'd1);
        check("load_ovf_clear", {31'h0, load_ovf}, 32'd0);

        // Run to EBREAK
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        check("run_core_rst", {31'h0, core_rst}, 32'd0);
        en_cycles = 0;
        for (int k = 0; k < 20 && state_o != 3'd5; k++) begin
            if (core_en) en_cycles++;
            tick();
        end
        check("run_halted", {29'h0, state_o}, 32'd5);
        check("run_en_cycles", en_cycles, 32'd2);
        check("run_halt_pc", halt_pc, 32'd8);
        check("run_retired", retired_cnt, 32'd2);
        check("run_cycles", cycle_cnt, 32'd3);

        // Soft reset preserves counters; reload a NOP program ending in EBREAK
        cmd_reset = 1'b1;
        tick();
        cmd_reset = 1'b0;
        check("sreset_state", {29'h0, state_o}, 32'd0);
        check("sreset_core_rst", {31'h0, core_rst}, 32'd1);
        check("sreset_retired_kept", retired_cnt, 32'd2);
        repeat (4) tick();
        check("sreset_idle", {29'h0, state_o}, 32'd1);
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        check("load2_cnt_clear", cycle_cnt, 32'd0);
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_data  = (i == 5) ? Ebreak : Nop;
            ld_last  = (i == 5);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();
        check("load2_idle", {29'h0, state_o}, 32'd1);

        // Halt and run together while running: halt wins, halt_pc = PC+4
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        repeat (2) tick();
        check("prio_pre_en", {31'h0, core_en}, 32'd1);
        cmd_halt = 1'b1;
        cmd_run  = 1'b1;
        tick();
        cmd_halt = 1'b0;
        cmd_run  = 1'b0;
        check("prio_halted", {29'h0, state_o}, 32'd5);
        check("prio_en_off", {31'h0, core_en}, 32'd0);
        tick();
        check("prio_halt_pc", halt_pc, 32'd12);
        check("prio_retired", retired_cnt, 32'd3);

        // Single step on a NOP
        do_step();
        check("step_state", {29'h0, state_o}, 32'd4);
        check("step_en", {31'h0, core_en}, 32'd1);
        tick();
        check("step_back_halted", {29'h0, state_o}, 32'd5);
        check("step_en_off", {31'h0, core_en}, 32'd0);
        tick();
        check("step_halt_pc", halt_pc, 32'd16);
        check("step_retired", retired_cnt, 32'd4);
        check("step_cycles", cycle_cnt, 32'd4);

        // Step onto EBREAK, then step on EBREAK retires nothing
        do_step();
        repeat (2) tick();
        check("step2_halt_pc", halt_pc, 32'd20);
        do_step();
        check("step_ebreak_en", {31'h0, core_en}, 32'd0);
        tick();
        check("step_ebreak_halted", {29'h0, state_o}, 32'd5);
        check("step_ebreak_retired", retired_cnt, 32'd5);
        check("step_ebreak_pc", halt_pc, 32'd20);
        check("step_ebreak_cycles", cycle_cnt, 32'd6);

        // cmd_reset aborts a load; the accepted beat is still written once
        pulse_cmd_reset_and_wait();
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        wbase     = wr_addr.size();
        ld_valid  = 1'b1;
        ld_data   = 32'hDEADBEEF;
        cmd_reset = 1'b1;
        tick();
        ld_valid  = 1'b0;
        cmd_reset = 1'b0;
        check("abort_state", {29'h0, state_o}, 32'd0);
        check("abort_we", {31'h0, imem_we}, 32'd1);
        check("abort_addr", {26'h0, imem_addr}, 32'd0);
        check("abort_wdata", imem_wdata, 32'hDEADBEEF);
        tick();
        check("abort_we_off", {31'h0, imem_we}, 32'd0);
        check("abort_nwrites", wr_addr.size() - wbase, 32'd1);

        // Overflow on the 4-word instance
        s_cmd_load = 1'b1;
        tick();
        s_cmd_load = 1'b0;
        check("ovf_load_state", {29'h0, s_state}, 32'd2);
        wbase = sw_addr.size();
        for (int i = 0; i < 5; i++) begin
            s_ld_valid = 1'b1;
            ld_data    = 32'hA0 + i;
            ld_last    = 1'b0;
            if (i == 4) check("ovf_5th_not_ready", {31'h0, s_ld_ready}, 32'd0);
            tick();
        end
        s_ld_valid = 1'b0;
        tick();
        check("ovf_nwrites", sw_addr.size() - wbase, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (sw_addr.size() > wbase + i) begin
                check($sformatf("ovf_addr%0d", i), sw_addr[wbase + i], i);
                check($sformatf("ovf_data%0d", i), sw_data[wbase + i], 32'hA0 + i);
            end
        end
        check("ovf_flag", {31'h0, s_load_ovf}, 32'd1);
        check("ovf_idle", {29'h0, s_state}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run/debug sequencer for the single-cycle RISC core.
- Holds the core in reset and streams a program into instruction memory over a valid/ready load port.
- Releases the core and gates its clock enable for run, halt and single-step.
- Stops automatically on EBREAK and keeps cycle and retired-instruction counters for the bench and debug host.

Parameters:
- IMEM_DEPTH, 64, instruction-memory depth in 32-bit words (power of 2, ≥2)
- AW, 6, word-address width, equal to log2(IMEM_DEPTH)
- RST_HOLD, 4, cycles core_rst is held after reset or cmd_reset (≥1)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_load  in  1  request a program load (one-cycle pulse)
- cmd_run  in  1  free-run request
- cmd_halt  in  1  halt request
- cmd_step  in  1  execute exactly one instruction
- cmd_reset  in  1  soft restart of the core
- ld_valid  in  1  load beat valid
- ld_data  in  32  instruction word
- ld_last  in  1  final beat of the program
- ld_ready  out  1  controller accepts a beat
- instr_in  in  32  core's current instruction (INSTR_OUT)
- pc_in  in  32  core's current PC (PC_OUT)
- core_rst  out  1  active-high reset to the core
- core_en  out  1  core clock enable; PC and register/memory writes advance only when 1
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  AW  write word address
- imem_wdata  out  32  write data
- state_o  out  3  0 RESET_HOLD, 1 IDLE, 2 LOAD, 3 RUN, 4 STEP, 5 HALTED
- halt_pc  out  32  PC captured at the last halt
- load_ovf  out  1  sticky: memory filled before ld_last
- cycle_cnt  out  CNT_W  cycles spent in RUN or STEP
- retired_cnt  out  CNT_W  cycles with core_en=1

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RESET_HOLD, hold counter cleared.
  - core_rst=1, core_en=0, ld_ready=0, imem_we=0.
  - imem_addr=0, imem_wdata=0, halt_pc=0, load_ovf=0, both counters 0.
- core_en is combinational:
  - core_en = (state==RUN or STEP) and instr_in != 32'h00100073 (EBREAK).
  - All other outputs are registered.
- core_rst=1 in RESET_HOLD, IDLE and LOAD; core_rst=0 in RUN, STEP and HALTED.
- Command priority when several commands arrive in one cycle: cmd_reset > cmd_halt > cmd_step > cmd_run > cmd_load. A command that does not apply in the current state is ignored.
- RESET_HOLD: stays RST_HOLD cycles, then goes to IDLE.
- IDLE:
  - cmd_load → LOAD; imem_addr=0, load_ovf=0, counters cleared.
  - cmd_run → RUN.
  - cmd_step → STEP.
- LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready: next cycle imem_we=1, imem_wdata=ld_data, imem_addr=current word pointer. The write lands one cycle after acceptance; the pointer then increments.
  - ld_last accepted → IDLE.
  - Beat accepted at pointer IMEM_DEPTH-1 without ld_last → load_ovf=1, go to IDLE. The pointer never wraps.
  - cmd_reset aborts the load; the in-flight write (if any) still completes on the next cycle.
- RUN:
  - cycle_cnt increments every cycle.
  - retired_cnt increments when core_en=1.
  - instr_in==EBREAK → HALTED next cycle with halt_pc=pc_in. core_en is already 0 that cycle, so the PC stays on the EBREAK.
  - cmd_halt → HALTED; the instruction of the current cycle completes; halt_pc=PC+4 (the pc_in seen next cycle).
- STEP: lasts exactly one cycle (core_en=1 unless EBREAK), counts as RUN, then → HALTED with halt_pc captured.
- HALTED:
  - core_en=0.
  - cmd_step → STEP.
  - cmd_run → RUN.
  - cmd_load → LOAD; core_rst reasserts.
  - When instr_in is EBREAK, run and step re-halt immediately, with 0 instructions retired.
- cmd_reset in any state except RESET_HOLD → RESET_HOLD; core_rst rises next cycle. Counters and load_ovf are preserved.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-load or mid-run: immediate return to reset values; a partial program remains in memory.

Test Plan:
- Reset: rst for 3 cycles → state_o=0 and core_rst=1. After release, exactly 4 cycles later state_o=1.
- Load: cmd_load then 3 beats (0x00500093, 0x00100113, 0x00100073, last on 3rd) with ld_valid toggling → imem_we pulses at addresses 0,1,2 carrying those words, one cycle after each accept; state_o=1; load_ovf=0.
- Run and EBREAK: cmd_run with the program above → core_rst=0; core_en=1 for 2 cycles; halt on 0x00100073 with halt_pc=8, retired_cnt=2, cycle_cnt=3.
- Step: from HALTED on a non-EBREAK instruction, cmd_step → core_en high for exactly 1 cycle, retired_cnt+1, halt_pc advances by 4, state_o back to 5.
- Overflow: IMEM_DEPTH=4, stream 5 beats without ld_last → 4 writes (addresses 0–3), load_ovf=1, 5th beat not accepted (ld_ready=0).
- Priority and abort: cmd_halt and cmd_run in the same cycle while in RUN → HALTED. cmd_reset mid-load → RESET_HOLD, pending write still issued once.
